// File: rtl/mem_pll_arbiter_pkg.sv
// Shared types and default widths for the memory/PLL arbiter slice.
// Holds the qualifier state encoding and the selected-request bundle.
package mem_pll_arbiter_pkg;

    localparam int MEM_ADDR_W = 10;
    localparam int MEM_DATA_W = 16;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        QUALIFY   = 2'd1,
        RUN       = 2'd2
    } arb_state_t;

    // Widths follow the MemGen_16_10 macro.
    typedef struct packed {
        logic                  we;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/lock_qualifier.sv
// PLL lock synchroniser, stability counter and WAIT_LOCK/QUALIFY/RUN FSM.
// Ports: clock, reset_n (async low), pll_lock (async in), run (registered).
module lock_qualifier
    import mem_pll_arbiter_pkg::*;
#(
    parameter int LOCK_SYNC = 2,
    parameter int LOCK_WAIT = 16
) (
    input  logic clock,
    input  logic reset_n,
    input  logic pll_lock,
    output logic run
);

    localparam logic [7:0] CNT_LAST = 8'(LOCK_WAIT - 1);

    logic [LOCK_SYNC-1:0] sync_q;
    logic                 lock_s;
    logic [7:0]           cnt;
    arb_state_t           state;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[LOCK_SYNC-2:0], pll_lock};
        end
    end

    assign lock_s = sync_q[LOCK_SYNC-1];

    // run is registered alongside the state so it is high exactly in RUN.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
            run   <= 1'b0;
        end else begin
            unique case (state)
                WAIT_LOCK: begin
                    cnt <= '0;
                    run <= 1'b0;
                    if (lock_s) state <= QUALIFY;
                end
                QUALIFY: begin
                    if (!lock_s) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= RUN;
                        run   <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        state <= WAIT_LOCK;
                        run   <= 1'b0;
                    end
                end
                default: begin
                    state <= WAIT_LOCK;
                    cnt   <= '0;
                    run   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/mem_pll_arbiter.sv
// Two-port round-robin arbiter for MemGen_16_10, gated by a qualified PLL lock.
// Ports: clock/reset_n, pll_lock, req0/req1 valid-ready + rsp, memory strobes,
// rd_data, mem_up. Macro MEM_PLL_ARBITER_PERF_EN adds perf_gnt0/1, perf_conflict.
module mem_pll_arbiter
    import mem_pll_arbiter_pkg::*;
#(
    parameter int ADDR_W    = MEM_ADDR_W,
    parameter int DATA_W    = MEM_DATA_W,
    parameter int LOCK_SYNC = 2,
    parameter int LOCK_WAIT = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              pll_lock,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              chip_en,
    output logic              wr_en,
    output logic              rd_en,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] rd_data,
    output logic              mem_up
`ifdef MEM_PLL_ARBITER_PERF_EN
    ,
    output logic [31:0]       perf_gnt0,
    output logic [31:0]       perf_gnt1,
    output logic [31:0]       perf_conflict
`endif
);

    logic              run;
    logic              last_grant;
    logic              gnt0;
    logic              gnt1;
    logic              granted;
    mem_req_t          sel;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              rsp0_q;
    logic              rsp1_q;

    lock_qualifier #(
        .LOCK_SYNC (LOCK_SYNC),
        .LOCK_WAIT (LOCK_WAIT)
    ) u_lock_qualifier (
        .clock    (clock),
        .reset_n  (reset_n),
        .pll_lock (pll_lock),
        .run      (run)
    );

    assign mem_up = run;

    // On conflict the requester not served last wins.
    always_comb begin
        gnt0 = run & req0_valid & (~req1_valid | last_grant);
        gnt1 = run & req1_valid & (~req0_valid | ~last_grant);
    end

    assign granted    = gnt0 | gnt1;
    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    always_comb begin
        sel = '0;
        if (gnt1) begin
            sel.we    = req1_we;
            sel.addr  = req1_addr;
            sel.wdata = req1_wdata;
        end else begin
            sel.we    = req0_we;
            sel.addr  = req0_addr;
            sel.wdata = req0_wdata;
        end
    end

    // Idle cycles replay the last address/data so the macro pins stay quiet.
    always_comb begin
        chip_en = granted;
        wr_en   = granted & sel.we;
        rd_en   = granted & ~sel.we;
        addr    = granted ? sel.addr : addr_q;
        wr_data = (granted & sel.we) ? sel.wdata : wdata_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= 1'b1;
            addr_q     <= '0;
            wdata_q    <= '0;
            rsp0_q     <= 1'b0;
            rsp1_q     <= 1'b0;
        end else begin
            if (gnt0) begin
                last_grant <= 1'b0;
            end else if (gnt1) begin
                last_grant <= 1'b1;
            end
            if (granted) addr_q <= sel.addr;
            if (granted & sel.we) wdata_q <= sel.wdata;
            rsp0_q <= gnt0 & ~req0_we;
            rsp1_q <= gnt1 & ~req1_we;
        end
    end

    // rd_data is only meaningful the cycle after rd_en; steer it there.
    assign rsp0_valid = rsp0_q;
    assign rsp1_valid = rsp1_q;
    assign rsp0_rdata = rsp0_q ? rd_data : '0;
    assign rsp1_rdata = rsp1_q ? rd_data : '0;

`ifdef MEM_PLL_ARBITER_PERF_EN
    // Counters only move in RUN; clearing outside RUN covers WAIT_LOCK entry.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            perf_gnt0     <= '0;
            perf_gnt1     <= '0;
            perf_conflict <= '0;
        end else if (!run) begin
            perf_gnt0     <= '0;
            perf_gnt1     <= '0;
            perf_conflict <= '0;
        end else begin
            if (gnt0 && perf_gnt0 != '1) begin
                perf_gnt0 <= perf_gnt0 + 32'd1;
            end
            if (gnt1 && perf_gnt1 != '1) begin
                perf_gnt1 <= perf_gnt1 + 32'd1;
            end
            if (req0_valid && req1_valid && perf_conflict != '1) begin
                perf_conflict <= perf_conflict + 32'd1;
            end
        end
    end
`endif

`ifndef SYNTHESIS
    a_one_ready : assert property (
        @(posedge clock) disable iff (!reset_n)
        !(req0_ready && req1_ready));

    a_hold0 : assert property (
        @(posedge clock) disable iff (!reset_n)
        (req0_valid && !req0_ready) |=>
        (req0_valid && $stable(req0_we) &&
         $stable(req0_addr) && $stable(req0_wdata)));

    a_hold1 : assert property (
        @(posedge clock) disable iff (!reset_n)
        (req1_valid && !req1_ready) |=>
        (req1_valid && $stable(req1_we) &&
         $stable(req1_addr) && $stable(req1_wdata)));
`endif

endmodule

// File: tb/tb_mem_pll_arbiter.sv
// Directed bench for mem_pll_arbiter with a behavioural 16x1024 memory.
// Covers lock qualification, glitch restart, round-robin, read return, lock loss.
module tb_mem_pll_arbiter;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        pll_lock;
    logic        req0_valid, req0_ready, req0_we;
    logic [9:0]  req0_addr;
    logic [15:0] req0_wdata;
    logic        rsp0_valid;
    logic [15:0] rsp0_rdata;
    logic        req1_valid, req1_ready, req1_we;
    logic [9:0]  req1_addr;
    logic [15:0] req1_wdata;
    logic        rsp1_valid;
    logic [15:0] rsp1_rdata;
    logic        chip_en, wr_en, rd_en;
    logic [9:0]  addr;
    logic [15:0] wr_data;
    logic [15:0] rd_data;
    logic        mem_up;
`ifdef MEM_PLL_ARBITER_PERF_EN
    logic [31:0] perf_gnt0, perf_gnt1, perf_conflict;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] mem [0:1023];

    always #5 clock = ~clock;

    mem_pll_arbiter dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .pll_lock   (pll_lock),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_we    (req0_we),
        .req0_addr  (req0_addr),
        .req0_wdata (req0_wdata),
        .rsp0_valid (rsp0_valid),
        .rsp0_rdata (rsp0_rdata),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_we    (req1_we),
        .req1_addr  (req1_addr),
        .req1_wdata (req1_wdata),
        .rsp1_valid (rsp1_valid),
        .rsp1_rdata (rsp1_rdata),
        .chip_en    (chip_en),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .addr       (addr),
        .wr_data    (wr_data),
        .rd_data    (rd_data),
        .mem_up     (mem_up)
`ifdef MEM_PLL_ARBITER_PERF_EN
        ,
        .perf_gnt0     (perf_gnt0),
        .perf_gnt1     (perf_gnt1),
        .perf_conflict (perf_conflict)
`endif
    );

    always @(posedge clock) begin
        if (chip_en) begin
            if (wr_en) mem[addr] <= wr_data;
            if (rd_en) rd_data <= mem[addr];
        end
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic bring_up();
        pll_lock = 1'b1;
        do_reset();
        repeat (19) step();
        check("bring_up mem_up", 32'(mem_up), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0;
        rd_data    = 16'h0;
        reset_n    = 1'b0;
        pll_lock   = 1'b1;
        req0_valid = 1'b1;
        req0_we    = 1'b0;
        req0_addr  = 10'h000;
        req0_wdata = 16'h0;
        req1_valid = 1'b0;
        req1_we    = 1'b0;
        req1_addr  = 10'h000;
        req1_wdata = 16'h0;

        // Reset state with a request already pending.
        repeat (2) @(posedge clock);
        #1;
        check("rst mem_up", 32'(mem_up), 32'd0);
        check("rst ready0", 32'(req0_ready), 32'd0);
        check("rst chip_en", 32'(chip_en), 32'd0);
        check("rst rsp0", 32'(rsp0_valid), 32'd0);
        check("rst addr", 32'(addr), 32'd0);

        // Lock qualification: mem_up rises on edge 19.
        @(negedge clock);
        reset_n = 1'b1;
        for (int k = 1; k <= 19; k++) begin
            step();
            check($sformatf("qual mem_up e%0d", k),
                  32'(mem_up), 32'(k >= 19));
            check($sformatf("qual chip_en e%0d", k),
                  32'(chip_en), 32'(k >= 19));
        end
        check("qual ready0", 32'(req0_ready), 32'd1);
        check("qual rd_en", 32'(rd_en), 32'd1);
        step();
        req0_valid = 1'b0;
        check("qual rsp0", 32'(rsp0_valid), 32'd1);
        check("qual rsp0 data", 32'(rsp0_rdata), 32'h0);

        // One-cycle lock glitch seen at count 10 restarts qualification.
        pll_lock = 1'b1;
        do_reset();
        for (int k = 1; k <= 31; k++) begin
            step();
            check($sformatf("glitch mem_up e%0d", k),
                  32'(mem_up), 32'(k >= 31));
            if (k == 11) pll_lock = 1'b0;
            if (k == 12) pll_lock = 1'b1;
        end

        // Solo writes, no responses.
        req0_valid = 1'b1; req0_we = 1'b1;
        req0_addr = 10'h001; req0_wdata = 16'hA001;
        #1;
        check("wr0 ready0", 32'(req0_ready), 32'd1);
        check("wr0 wr_en", 32'(wr_en), 32'd1);
        check("wr0 addr", 32'(addr), 32'h001);
        check("wr0 wr_data", 32'(wr_data), 32'hA001);
        step();
        req0_valid = 1'b0;
        check("wr0 rsp0", 32'(rsp0_valid), 32'd0);
        req1_valid = 1'b1; req1_we = 1'b1;
        req1_addr = 10'h002; req1_wdata = 16'hB002;
        #1;
        check("wr1 ready1", 32'(req1_ready), 32'd1);
        check("wr1 ready0", 32'(req0_ready), 32'd0);
        check("wr1 wr_data", 32'(wr_data), 32'hB002);
        step();
        req1_valid = 1'b0;
        check("wr1 rsp1", 32'(rsp1_valid), 32'd0);

        // Conflicting reads alternate 0,1,0,1.
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 10'h001;
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 10'h002;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("rr ready0 c%0d", i),
                  32'(req0_ready), 32'(i % 2 == 0));
            check($sformatf("rr ready1 c%0d", i),
                  32'(req1_ready), 32'(i % 2 == 1));
            check($sformatf("rr addr c%0d", i),
                  32'(addr), (i % 2 == 0) ? 32'h001 : 32'h002);
            step();
            check($sformatf("rr rsp0 c%0d", i),
                  32'(rsp0_valid), 32'(i % 2 == 0));
            check($sformatf("rr rsp1 c%0d", i),
                  32'(rsp1_valid), 32'(i % 2 == 1));
            check($sformatf("rr rdata0 c%0d", i),
                  32'(rsp0_rdata), (i % 2 == 0) ? 32'hA001 : 32'h0);
            check($sformatf("rr rdata1 c%0d", i),
                  32'(rsp1_rdata), (i % 2 == 1) ? 32'hB002 : 32'h0);
        end
        req1_valid = 1'b0;
        #1;
        check("rr tail ready0", 32'(req0_ready), 32'd1);
        step();
        req0_valid = 1'b0;
        check("rr tail rdata0", 32'(rsp0_rdata), 32'hA001);

        // Write then read same address at the top of the array.
        req0_valid = 1'b1; req0_we = 1'b1;
        req0_addr = 10'h3FF; req0_wdata = 16'hBEEF;
        #1;
        check("wtr wr_en", 32'(wr_en), 32'd1);
        step();
        req0_we = 1'b0;
        #1;
        check("wtr rd_en", 32'(rd_en), 32'd1);
        check("wtr addr", 32'(addr), 32'h3FF);
        step();
        req0_valid = 1'b0;
        check("wtr rsp0", 32'(rsp0_valid), 32'd1);
        check("wtr rdata0", 32'(rsp0_rdata), 32'hBEEF);
        check("wtr rsp1", 32'(rsp1_valid), 32'd0);
        step();
        check("idle rsp0", 32'(rsp0_valid), 32'd0);
        check("idle chip_en", 32'(chip_en), 32'd0);
        check("idle addr hold", 32'(addr), 32'h3FF);
        check("idle wr_data hold", 32'(wr_data), 32'hBEEF);

        // Lock lost in the cycle of a req1 read grant.
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 10'h002;
        pll_lock = 1'b0;
        #1;
        check("loss ready1", 32'(req1_ready), 32'd1);
        step();
        req1_valid = 1'b0;
        check("loss rsp1", 32'(rsp1_valid), 32'd1);
        check("loss rdata1", 32'(rsp1_rdata), 32'hB002);
        step();
        check("loss mem_up e1", 32'(mem_up), 32'd1);
        step();
        check("loss mem_up e2", 32'(mem_up), 32'd0);
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 10'h001;
        #1;
        check("loss ready0", 32'(req0_ready), 32'd0);
        check("loss chip_en", 32'(chip_en), 32'd0);
        step();
        check("loss ready0 later", 32'(req0_ready), 32'd0);
        reset_n = 1'b0;
        #1;
        req0_valid = 1'b0;

        // Async reset discards a pending response.
        bring_up();
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 10'h001;
        step();
        check("arst rsp0 before", 32'(rsp0_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        req0_valid = 1'b0;
        check("arst rsp0", 32'(rsp0_valid), 32'd0);
        check("arst mem_up", 32'(mem_up), 32'd0);

`ifdef MEM_PLL_ARBITER_PERF_EN
        bring_up();
        check("perf clr gnt0", perf_gnt0, 32'd0);
        check("perf clr conf", perf_conflict, 32'd0);
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 10'h001;
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 10'h002;
        repeat (5) step();
        req0_valid = 1'b0;
        repeat (3) step();
        req1_valid = 1'b0;
        check("perf conflict", perf_conflict, 32'd5);
        check("perf gnt0", perf_gnt0, 32'd3);
        check("perf gnt1", perf_gnt1, 32'd5);
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
